openila_capture_ctrl: RTL

- Capture sequencer for the logic analyser; sits between the sample compressor and the sample RAM.
- Gates raw samples into the compressor and detects the trigger on raw samples.
- Writes compressed words into a circular RAM, counts post-trigger words, then stops.
- Exposes status and the pointers that the readout logic needs to unroll the circular buffer.

---
 rtl/openila_capture_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/openila_capture_ctrl.sv
// openila_capture_ctrl: capture sequencer between the sample compressor and
// the circular sample RAM. Gates raw samples into the compressor, detects
// the trigger on raw samples, writes compressed words into the ring and
// stops after the programmed number of post-trigger words. Also exposes the
// pointers the readout logic needs to unroll the ring.
module openila_capture_ctrl #(
  parameter int W_SAMPLE = 8,
  parameter int W_MEM    = 9,
  parameter int W_ADDR   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                abort,
  input  logic [W_ADDR-1:0]   post_count,
  input  logic [W_SAMPLE-1:0] trig_mask,
  input  logic [W_SAMPLE-1:0] trig_value,
  input  logic [W_SAMPLE-1:0] din,
  input  logic                din_valid,
  output logic                comp_clear,
  output logic                comp_din_valid,
  input  logic [W_MEM-1:0]    comp_dout,
  input  logic                comp_dout_valid,
  output logic                ram_wen,
  output logic [W_ADDR-1:0]   ram_waddr,
  output logic [W_MEM-1:0]    ram_wdata,
  output logic                armed,
  output logic                triggered,
  output logic                done,
  output logic                wrapped,
  output logic [W_ADDR-1:0]   trig_addr,
  output logic [W_ADDR-1:0]   start_addr,
  output logic [W_ADDR-1:0]   end_addr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRETRIG  = 2'd1,
    S_POSTTRIG = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [W_ADDR-1:0] ADDR_ONE = W_ADDR'(1);
  localparam logic [W_ADDR-1:0] ADDR_MAX = '1;

  state_t                state_q, state_d;
  logic [W_ADDR-1:0]     post_count_q, post_count_d;
  logic [W_SAMPLE-1:0]   trig_mask_q, trig_mask_d;
  logic [W_SAMPLE-1:0]   trig_value_q, trig_value_d;
  logic [W_ADDR-1:0]     wptr_q, wptr_d;
  logic [W_ADDR-1:0]     remaining_q, remaining_d;
  logic [W_ADDR-1:0]     trig_addr_q, trig_addr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  triggered_q, triggered_d;
  logic                  comp_clear_q;
  logic                  armed_q;
  logic                  done_q;
  logic [W_ADDR-1:0]     start_addr_q;
  logic                  ram_wen_q;
  logic [W_ADDR-1:0]     ram_waddr_q;
  logic [W_MEM-1:0]      ram_wdata_q;

  logic                  capturing;
  logic                  trig_hit;
  logic                  arm_ok;
  logic                  pc_zero;
  logic                  wr_en;

  // Decode of the current cycle: trigger match, arm acceptance, word write.
  // Abort suppresses any write on its own cycle; a zero post-count trigger
  // drops the word that arrives with it.
  always_comb begin
    capturing = (state_q == S_PRETRIG) || (state_q == S_POSTTRIG);
    trig_hit  = (state_q == S_PRETRIG) && din_valid &&
                (((din ^ trig_value_q) & trig_mask_q) == '0);
    arm_ok    = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    pc_zero   = (post_count_q == '0);
    wr_en     = capturing && comp_dout_valid && !abort && !(trig_hit && pc_zero);
  end

  // Next-state logic for the sequencer, pointers and trigger bookkeeping.
  always_comb begin
    state_d      = state_q;
    post_count_d = post_count_q;
    trig_mask_d  = trig_mask_q;
    trig_value_d = trig_value_q;
    wptr_d       = wptr_q;
    remaining_d  = remaining_q;
    trig_addr_d  = trig_addr_q;
    wrapped_d    = wrapped_q;
    triggered_d  = triggered_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_ok) begin
          state_d      = S_PRETRIG;
          post_count_d = post_count;
          trig_mask_d  = trig_mask;
          trig_value_d = trig_value;
          wptr_d       = '0;
          wrapped_d    = 1'b0;
          triggered_d  = 1'b0;
        end
      end
      S_PRETRIG: begin
        if (trig_hit) begin
          triggered_d = 1'b1;
          trig_addr_d = wptr_q;
          if (pc_zero) begin
            state_d = S_DONE;
          end else if (wr_en) begin
            // The word arriving with the trigger is post-trigger word 1.
            remaining_d = post_count_q - ADDR_ONE;
            state_d     = (post_count_q == ADDR_ONE) ? S_DONE : S_POSTTRIG;
          end else begin
            remaining_d = post_count_q;
            state_d     = S_POSTTRIG;
          end
        end
      end
      S_POSTTRIG: begin
        if (wr_en) begin
          remaining_d = remaining_q - ADDR_ONE;
          if (remaining_q == ADDR_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ring pointer advance; the wrap back to zero marks old data overwritten.
    if (wr_en) begin
      wptr_d = wptr_q + ADDR_ONE;
      if (wptr_q == ADDR_MAX) begin
        wrapped_d = 1'b1;
      end
    end

    // Abort wins over everything else but leaves pointers for readback.
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // State, pointer and registered-output update; reset drops in-flight writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      post_count_q <= '0;
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      wptr_q       <= '0;
      remaining_q  <= '0;
      trig_addr_q  <= '0;
      wrapped_q    <= 1'b0;
      triggered_q  <= 1'b0;
      comp_clear_q <= 1'b0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
      start_addr_q <= '0;
      ram_wen_q    <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      post_count_q <= post_count_d;
      trig_mask_q  <= trig_mask_d;
      trig_value_q <= trig_value_d;
      wptr_q       <= wptr_d;
      remaining_q  <= remaining_d;
      trig_addr_q  <= trig_addr_d;
      wrapped_q    <= wrapped_d;
      triggered_q  <= triggered_d;
      comp_clear_q <= arm_ok;
      armed_q      <= (state_d == S_PRETRIG);
      done_q       <= (state_d == S_DONE);
      start_addr_q <= wrapped_d ? wptr_d : '0;
      ram_wen_q    <= wr_en;
      if (wr_en) begin
        ram_waddr_q <= wptr_q;
        ram_wdata_q <= comp_dout;
      end
    end
  end

  assign comp_din_valid = din_valid && capturing;
  assign comp_clear     = comp_clear_q;
  assign ram_wen        = ram_wen_q;
  assign ram_waddr      = ram_waddr_q;
  assign ram_wdata      = ram_wdata_q;
  assign armed          = armed_q;
  assign triggered      = triggered_q;
  assign done           = done_q;
  assign wrapped        = wrapped_q;
  assign trig_addr      = trig_addr_q;
  assign start_addr     = start_addr_q;
  assign end_addr       = wptr_q;

endmodule
